gpu_tilemap: RTL and testbench
==============================

# gpu_tilemap

Parametrised successor to the blank-screen GPU top level: generates display timing and renders a 40×30 grid of 8×8, 2-bit-per-pixel tiles from internal VRAM, with pixels doubled vertically to fill 320×480. Sits between the CPU-side VRAM write interface and the DVI encoder. It adds a frame-latched display-enable control, and delays sync to match the pixel pipeline.

## Interface
- `H_VISIBLE`, 320: active pixels per line
- `H_FRONT` / `H_SYNC` / `H_BACK`, 8 / 48 / 24: horizontal porch and sync widths in clocks (400 total)
- `V_VISIBLE`, 480: active lines
- `V_FRONT` / `V_SYNC` / `V_BACK`, 10 / 2 / 33: vertical porch and sync widths in lines (525 total)
- `SYNC_ACTIVE`, 0: asserted level of `hsync`/`vsync`
- `COLOR_BITS`, 2: bits per colour channel
- `V_SCALE`, 2: vertical line-repeat factor
- `VRAM_ADDR_WIDTH`, 12: VRAM address width

Ports:
- `clk` in 1: pixel clock, 12.5875 MHz; only clock
- `rst` in 1: synchronous, active-high reset
- `r`, `g`, `b` out `COLOR_BITS`: pixel colour
- `hsync`, `vsync` out 1: syncs, aligned with colour
- `data` in 8: VRAM write data
- `address` in `VRAM_ADDR_WIDTH`: VRAM write address
- `cs` in 1: write strobe; one byte written per cycle high

## Operation
- VRAM map. Writes outside these ranges are ignored.
  - 0x000–0x4AF: nametable, row-major, 40 bytes per row.
  - 0x4B0–0x4B3: palette entries 0–3, `{r,g,b}` in the low 6 bits.
  - 0x4B4: control; bit0 = display enable.
  - 0x800–0xBFF: pattern table.
- Pattern address = 0x800 + tile[5:0]·16 + row·2 + plane.
  - Nametable byte bits 7:6 are ignored.
  - Pixel column x uses bit (7−x) of both planes.
  - Colour index = `{plane1, plane0}`.
- Coordinates:
  - Tile column = hcount/8; pixel column = hcount%8.
  - Source line = vcount/`V_SCALE`; tile row = line/8; pattern row = line%8.
- Counters:
  - hcount runs 0..399, then wraps to 0.
  - vcount advances when hcount wraps, runs 0..524, then wraps to 0.
  - Visible region: hcount < `H_VISIBLE` and vcount < `V_VISIBLE`.
- Sync windows:
  - hsync asserted for hcount in [328, 376).
  - vsync asserted for vcount in [490, 492).
- Display enable:
  - A write to 0x4B4 updates a shadow bit.
  - The shadow bit copies to the live enable only on the cycle hcount=0, vcount=`V_VISIBLE`, i.e. start of vertical blank. No mid-frame tearing.
- Colour output is zero whenever the delayed visible flag is 0 or the live enable is 0.
- Pattern and nametable RAMs: one write port, one read port, read-first on same-address collision. A collision returns old data; the new data shows from the next read.
- Palette and control registers take effect on the cycle after the write.
- Reset state:
  - Counters are 0; `r`/`g`/`b` are 0.
  - `hsync`/`vsync` sit at `!SYNC_ACTIVE`.
  - Palette entries, shadow enable and live enable are 0.
  - Pipeline valid bits are cleared.
  - RAM contents are not cleared; with enable 0 the screen stays black.
- Reset mid-frame: restarts at hcount=vcount=0 on the next cycle. Outputs go black and syncs inactive immediately; no partial-pipeline pixel escapes.

## Timing
- Pipeline, 3 stages; colour for counter position (h,v) appears 3 clocks after the counters hold (h,v):
  - S0: counters; nametable read address issued.
  - S1: tile index valid; pattern reads of both planes issued.
  - S2: plane bytes valid; palette lookup registered into `r`/`g`/`b`.
- hsync, vsync and visible are delayed through 3 matching registers, so a sync edge and the first/last active pixel keep their nominal porch spacing at the outputs.
- After `rst` falls: first `hsync` assertion at output on clock 328+3; first visible pixel on clock 3.
- Write-to-pixel latency: a pattern or nametable write at cycle t is visible to an S0 read issued at t+1 or later.

## Structure
- Timing constants, VRAM region bases and sizes, and the control-register address go in `parameters.v`, alongside `VRAM_ADDR_WIDTH`.
- One sub-module, `gpu_timing`: parametrised h/v counters, visible flags and raw syncs.
- Nametable RAM, pattern RAM, palette/control registers and the pipeline stay in the top module.

## Test plan
- Reset, then 525×400 clocks with no writes → `r`=`g`=`b`=0 throughout. `hsync` low for exactly 48 clocks per line; `vsync` low for exactly 2 lines per frame.
- Write palette {0x00,0x30,0x0C,0x03}, tile 1 planes = 0xFF/0x00 for all rows, nametable[0]=1, enable=1; wait one frame → pixels 0–7 of lines 0–15 have `r`=3, `g`=0, `b`=0. Pixel 8 is black.
- Write enable=1 at vcount=100 → remaining lines of that frame stay black; the next frame renders.
- Write nametable[5] at the cycle S0 reads address 5 → that pixel shows the old tile; the next frame shows the new one.
- Assert `rst` for 1 cycle at hcount=200, vcount=300 → next cycle outputs black and syncs inactive; counters restart at 0 and timing repeats the first scenario.
- Write 0x5A to 0x600 (unmapped) and to 0xC00 → no change to any rendered pixel; palette and control readback unaffected.

Source files
------------

// File: rtl/gpu_tilemap_pkg.sv
// Shared constants for the tile-map GPU: default display timing and VRAM layout.
// The nametable lives at address 0; its size follows from the active geometry.
package gpu_tilemap_pkg;

    localparam int DEF_H_VISIBLE       = 320;
    localparam int DEF_H_FRONT         = 8;
    localparam int DEF_H_SYNC          = 48;
    localparam int DEF_H_BACK          = 24;
    localparam int DEF_V_VISIBLE       = 480;
    localparam int DEF_V_FRONT         = 10;
    localparam int DEF_V_SYNC          = 2;
    localparam int DEF_V_BACK          = 33;
    localparam bit DEF_SYNC_ACTIVE     = 1'b0;
    localparam int DEF_COLOR_BITS      = 2;
    localparam int DEF_V_SCALE         = 2;
    localparam int DEF_VRAM_ADDR_WIDTH = 12;

    localparam int TILE_PX         = 8;
    localparam int PAL_BASE        = 'h4B0;
    localparam int CTRL_ADDR       = 'h4B4;
    localparam int PAT_BASE        = 'h800;
    localparam int PAT_PLANE_DEPTH = 512;

endpackage

// File: rtl/gpu_tilemap_timing.sv
// Horizontal/vertical raster counters with visible-region flag and raw sync windows.
// Sync outputs are active-high "inside window"; polarity is applied by the caller.
module gpu_tilemap_timing
    import gpu_tilemap_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int HW        = 9,
    parameter int VW        = 10
) (
    input  logic          clk,
    input  logic          rst,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          visible,
    output logic          hsync_on,
    output logic          vsync_on
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount <= '0;
            vcount <= '0;
        end else if (hcount == HW'(H_TOTAL - 1)) begin
            hcount <= '0;
            if (vcount == VW'(V_TOTAL - 1))
                vcount <= '0;
            else
                vcount <= vcount + VW'(1);
        end else begin
            hcount <= hcount + HW'(1);
        end
    end

    assign visible  = (hcount < HW'(H_VISIBLE)) && (vcount < VW'(V_VISIBLE));
    assign hsync_on = (hcount >= HW'(H_VISIBLE + H_FRONT)) &&
                      (hcount <  HW'(H_VISIBLE + H_FRONT + H_SYNC));
    assign vsync_on = (vcount >= VW'(V_VISIBLE + V_FRONT)) &&
                      (vcount <  VW'(V_VISIBLE + V_FRONT + V_SYNC));

endmodule

// File: rtl/gpu_tilemap.sv
// Tile-map GPU top: VRAM write decode, 3-stage nametable/pattern/palette pipeline,
// frame-latched display enable, and syncs delayed to line up with colour.
module gpu_tilemap
    import gpu_tilemap_pkg::*;
#(
    parameter int H_VISIBLE       = DEF_H_VISIBLE,
    parameter int H_FRONT         = DEF_H_FRONT,
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int H_BACK          = DEF_H_BACK,
    parameter int V_VISIBLE       = DEF_V_VISIBLE,
    parameter int V_FRONT         = DEF_V_FRONT,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter int V_BACK          = DEF_V_BACK,
    parameter bit SYNC_ACTIVE     = DEF_SYNC_ACTIVE,
    parameter int COLOR_BITS      = DEF_COLOR_BITS,
    parameter int V_SCALE         = DEF_V_SCALE,
    parameter int VRAM_ADDR_WIDTH = DEF_VRAM_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [COLOR_BITS-1:0]      r,
    output logic [COLOR_BITS-1:0]      g,
    output logic [COLOR_BITS-1:0]      b,
    output logic                       hsync,
    output logic                       vsync,
    input  logic [7:0]                 data,
    input  logic [VRAM_ADDR_WIDTH-1:0] address,
    input  logic                       cs
);

    localparam int AW      = VRAM_ADDR_WIDTH;
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int TILES_X = H_VISIBLE / TILE_PX;
    localparam int TILES_Y = V_VISIBLE / V_SCALE / TILE_PX;
    localparam int NT_SIZE = TILES_X * TILES_Y;
    localparam int NT_AW   = $clog2(NT_SIZE);
    localparam int PAL_W   = 3 * COLOR_BITS;
    localparam logic [AW-1:0] PAL_A  = AW'(PAL_BASE);
    localparam logic [AW-1:0] PAT_A  = AW'(PAT_BASE);
    localparam logic [AW-1:0] CTRL_A = AW'(CTRL_ADDR);

    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          visible, hsync_on, vsync_on;

    gpu_tilemap_timing #(
        .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
        .HW(HW), .VW(VW)
    ) u_timing (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
        .visible(visible), .hsync_on(hsync_on), .vsync_on(vsync_on)
    );

    logic [VW-1:0]    line;
    logic [NT_AW-1:0] nt_raddr;
    assign line     = vcount / VW'(V_SCALE);
    assign nt_raddr = NT_AW'(line[VW-1:3]) * NT_AW'(TILES_X) + NT_AW'(hcount[HW-1:3]);

    logic nt_we, pat_we, pal_we, ctrl_we, latch_en;
    assign nt_we    = cs && (address < AW'(NT_SIZE));
    assign pat_we   = cs && (address[AW-1:10] == PAT_A[AW-1:10]);
    assign pal_we   = cs && (address[AW-1:2] == PAL_A[AW-1:2]);
    assign ctrl_we  = cs && (address == CTRL_A);
    assign latch_en = (hcount == '0) && (vcount == VW'(V_VISIBLE));

    logic [5:0]       nt_mem   [NT_SIZE];
    logic [7:0]       pat0_mem [PAT_PLANE_DEPTH];
    logic [7:0]       pat1_mem [PAT_PLANE_DEPTH];
    logic [5:0]       nt_q;
    logic [7:0]       p0_q, p1_q;
    logic [2:0]       px1, px2, prow1;
    logic             vis1, vis2, hs1, hs2, vs1, vs2;
    logic [PAL_W-1:0] pal [4];
    logic             en_shadow, en_live;
    logic [1:0]       pix_idx;

    // Non-blocking read with write in one block gives read-first collisions.
    always_ff @(posedge clk) begin
        if (nt_we)
            nt_mem[NT_AW'(address)] <= data[5:0];
        if (pat_we && !address[0])
            pat0_mem[address[9:1]] <= data;
        if (pat_we && address[0])
            pat1_mem[address[9:1]] <= data;
        nt_q <= nt_mem[nt_raddr];
        p0_q <= pat0_mem[{nt_q, prow1}];
        p1_q <= pat1_mem[{nt_q, prow1}];
    end

    // Pattern bytes hold pixel 0 in bit 7.
    assign pix_idx = {p1_q[~px2], p0_q[~px2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            pal       <= '{default: '0};
            en_shadow <= 1'b0;
            en_live   <= 1'b0;
            vis1      <= 1'b0;
            vis2      <= 1'b0;
            hs1       <= 1'b0;
            hs2       <= 1'b0;
            vs1       <= 1'b0;
            vs2       <= 1'b0;
            px1       <= '0;
            px2       <= '0;
            prow1     <= '0;
            r         <= '0;
            g         <= '0;
            b         <= '0;
            hsync     <= ~SYNC_ACTIVE;
            vsync     <= ~SYNC_ACTIVE;
        end else begin
            if (pal_we)
                pal[address[1:0]] <= data[PAL_W-1:0];
            if (ctrl_we)
                en_shadow <= data[0];
            if (latch_en)
                en_live <= en_shadow;
            vis1  <= visible;
            hs1   <= hsync_on;
            vs1   <= vsync_on;
            px1   <= hcount[2:0];
            prow1 <= line[2:0];
            vis2  <= vis1;
            hs2   <= hs1;
            vs2   <= vs1;
            px2   <= px1;
            if (vis2 && en_live)
                {r, g, b} <= pal[pix_idx];
            else
                {r, g, b} <= '0;
            hsync <= hs2 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync <= vs2 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

endmodule

// File: tb/tb_gpu_tilemap.sv
// Scoreboard bench for gpu_tilemap on a shrunken raster: a VRAM-level reference
// model predicts every output cycle, a monitor compares at the falling edge.
module tb_gpu_tilemap;

    localparam int HV = 64, HF = 4, HS = 8, HB = 4;
    localparam int VV = 32, VF = 2, VS = 2, VB = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int TX = HV / 8;
    localparam int NTS = TX * (VV / 2 / 8);
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0;
    logic [7:0]  data = '0;
    logic [11:0] address = '0;
    logic [1:0]  r, g, b;
    logic        hsync, vsync;

    always #5 clk = ~clk;

    gpu_tilemap #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE(1'b0), .COLOR_BITS(2), .V_SCALE(2), .VRAM_ADDR_WIDTH(12)
    ) dut (
        .clk(clk), .rst(rst), .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync),
        .data(data), .address(address), .cs(cs)
    );

    // Reference VRAM state and raster position.
    int nt_m [NTS];
    int pat_m [1024];
    int pal_m [4];
    bit shadow_m, live_m, model_on;
    int mh, mv;

    // A pixel request: position plus what each read returned when it was issued.
    typedef struct {
        bit vld;
        int h;
        int v;
        int tile;
        int p0;
        int p1;
    } rec_t;
    typedef struct {
        logic [7:0] val;
        int h;
        int v;
    } exp_t;

    rec_t ra, rb;
    exp_t exp_q[$];
    int checks = 0;
    int passes = 0;

    function automatic logic [7:0] render(rec_t rc);
        logic hs_l, vs_l;
        int x, idx, e;
        if (!rc.vld) return 8'h03;
        hs_l = !(rc.h >= HV + HF && rc.h < HV + HF + HS);
        vs_l = !(rc.v >= VV + VF && rc.v < VV + VF + VS);
        e = 0;
        if (rc.h < HV && rc.v < VV && live_m) begin
            x = rc.h % 8;
            idx = ((rc.p1 >> (7 - x)) & 1) * 2 + ((rc.p0 >> (7 - x)) & 1);
            e = pal_m[idx];
        end
        return {e[5:0], hs_l, vs_l};
    endfunction

    function automatic void apply_write(int a, int d);
        if (a < NTS) nt_m[a] = d;
        else if (a >= 'h4B0 && a <= 'h4B3) pal_m[a - 'h4B0] = d & 63;
        else if (a == 'h4B4) shadow_m = d[0];
        else if (a >= 'h800 && a < 'hC00) pat_m[a - 'h800] = d;
    endfunction

    // Reference model: a read issued at an edge sees every write before that edge.
    initial begin
        exp_t e;
        rec_t na, nb;
        int ln, base;
        model_on = 0;
        ra = '{default: 0};
        rb = '{default: 0};
        mh = 0;
        mv = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                model_on = 1;
                ra.vld = 0;
                rb.vld = 0;
                mh = 0;
                mv = 0;
                for (int i = 0; i < 4; i++) pal_m[i] = 0;
                shadow_m = 0;
                live_m = 0;
                e.val = 8'h03;
                e.h = -1;
                e.v = -1;
                exp_q.push_back(e);
            end else if (model_on) begin
                e.val = render(rb);
                e.h = rb.h;
                e.v = rb.v;
                exp_q.push_back(e);
                nb = ra;
                if (nb.vld) begin
                    ln = nb.v / 2;
                    base = nb.tile * 16 + (ln % 8) * 2;
                    nb.p0 = pat_m[base];
                    nb.p1 = pat_m[base + 1];
                end
                na.vld = 1;
                na.h = mh;
                na.v = mv;
                na.p0 = 0;
                na.p1 = 0;
                na.tile = (mh < HV && mv < VV) ? (nt_m[(mv / 16) * TX + mh / 8] & 63) : 0;
                ra = na;
                rb = nb;
                if (mh == 0 && mv == VV) live_m = shadow_m;
                if (cs) apply_write(int'(address), int'(data));
                mh++;
                if (mh == HT) begin
                    mh = 0;
                    mv = (mv + 1) % VT;
                end
            end
        end
    end

    // Monitor: one comparison per output cycle.
    initial begin
        exp_t e;
        logic [7:0] got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {r, g, b, hsync, vsync};
                checks++;
                if (got === e.val)
                    passes++;
                else
                    $display("FAIL pixel h=%0d v=%0d got=%h exp=%h (rgb,hs,vs)", e.h, e.v, got, e.val);
            end
        end
    end

    task automatic wr(input int a, input int d);
        address = 12'(a);
        data = 8'(d);
        cs = 1'b1;
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pos(input int h, input int v);
        int n = 0;
        while (!(mh == h && mv == v) && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2 * FRAME) begin
            checks++;
            $display("FAIL wait_pos h=%0d v=%0d reached=0 required=1", h, v);
        end
    endtask

    task automatic write_palette();
        wr('h4B0, 'h00);
        wr('h4B1, 'h30);
        wr('h4B2, 'h0C);
        wr('h4B3, 'h03);
    endtask

    initial begin
        int a, d;
        int unmapped [6];
        unmapped = '{'h600, 'hC00, 'h4B5, 'h7FF, 'hFFF, 'h100};
        for (int i = 0; i < NTS; i++) nt_m[i] = 0;
        for (int i = 0; i < 1024; i++) pat_m[i] = 0;
        idle(3);
        rst = 1'b0;
        idle(FRAME);

        for (int i = 0; i < 1024; i++) wr('h800 + i, $urandom_range(0, 255));
        for (int i = 0; i < 8; i++) begin
            wr('h810 + 2 * i, 'hFF);
            wr('h811 + 2 * i, 'h00);
        end
        for (int i = 0; i < NTS; i++) wr(i, $urandom_range(0, 255));
        wr(0, 1);
        write_palette();
        wr('h4B4, 1);
        idle(2 * FRAME);

        wr('h4B4, 0);
        idle(FRAME + 10);
        wait_pos(0, 10);
        wr('h4B4, 1);
        idle(2 * FRAME);

        wait_pos(40, 0);
        wr(5, (nt_m[5] + 1) & 63);
        idle(FRAME + 10);

        wait_pos(50, 20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(FRAME);
        write_palette();
        wr('h4B4, 1);
        idle(FRAME);

        wait_pos(0, 3);
        wr('h600, 'h5A);
        wr('hC00, 'h5A);
        idle(FRAME);

        repeat (5 * FRAME) begin
            if ($urandom_range(0, 5) == 0) begin
                d = $urandom_range(0, 255);
                case ($urandom_range(0, 5))
                    0: a = $urandom_range(0, NTS - 1);
                    1, 5: a = 'h800 + $urandom_range(0, 1023);
                    2: a = 'h4B0 + $urandom_range(0, 3);
                    3: begin
                        a = 'h4B4;
                        d = ($urandom_range(0, 3) != 0) ? 1 : 0;
                    end
                    default: a = unmapped[$urandom_range(0, 5)];
                endcase
                wr(a, d);
            end else begin
                @(negedge clk);
            end
        end
        idle(10);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
